// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one outstanding fetch at a time and holds a single slot for decode.
// Optional stall counter is compiled in with FETCH_PERFCNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] perfcnt_fetch_stall
);

    logic [31:0] pc_f_q, pc_f_d;
    logic        pending_q, pending_d;
    logic        halt_q, halt_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic        cancelled_q, cancelled_d;
    logic        exc_q, exc_d;
    logic [4:0]  exccode_q, exccode_d;

    logic slot_free;
    logic aligned;
    logic accept;
    logic misalign_load;

    always_comb begin
        slot_free     = !valid_q || ready_i;
        aligned       = (pc_f_q[1:0] == 2'b00);
        // Request is gated by reset so nothing leaks out while reset is held.
        inst_req      = !reset && slot_free && (!pending_q || inst_data_ok) && aligned &&
                        !halt_q && !redirect_i;
        accept        = inst_req && inst_addr_ok;
        misalign_load = slot_free && !aligned && !halt_q;
    end

    always_comb begin
        pc_f_d      = pc_f_q;
        pending_d   = pending_q;
        halt_d      = halt_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        cancelled_d = cancelled_q;
        exc_d       = exc_q;
        exccode_d   = exccode_q;

        // Data with nothing outstanding simply leaves pending at zero.
        if (accept) begin
            pending_d = 1'b1;
        end else if (inst_data_ok) begin
            pending_d = 1'b0;
        end

        if (redirect_i) begin
            pc_f_d = redirect_pc_i;
        end else if (accept) begin
            pc_f_d = pc_f_q + 32'd4;
        end

        if (redirect_i) begin
            halt_d = 1'b0;
        end else if (misalign_load) begin
            halt_d = 1'b1;
        end

        if (accept || misalign_load) begin
            valid_d     = 1'b1;
            pc_d        = pc_f_q;
            cancelled_d = redirect_i;
            exc_d       = misalign_load;
            exccode_d   = misalign_load ? 5'h04 : 5'h00;
        end else if (ready_i) begin
            valid_d     = 1'b0;
            cancelled_d = 1'b0;
            exc_d       = 1'b0;
        end else if (redirect_i && valid_q) begin
            // Stale slot stays visible so decode still absorbs its data_ok.
            cancelled_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q      <= RESET_PC;
            pending_q   <= 1'b0;
            halt_q      <= 1'b0;
            valid_q     <= 1'b0;
            pc_q        <= 32'd0;
            cancelled_q <= 1'b0;
            exc_q       <= 1'b0;
            exccode_q   <= 5'd0;
        end else begin
            pc_f_q      <= pc_f_d;
            pending_q   <= pending_d;
            halt_q      <= halt_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            cancelled_q <= cancelled_d;
            exc_q       <= exc_d;
            exccode_q   <= exccode_d;
        end
    end

    assign inst_addr   = pc_f_q;
    assign valid_o     = valid_q;
    assign pc_o        = pc_q;
    assign cancelled_o = cancelled_q;
    assign exc_o       = exc_q;
    assign exccode_o   = exccode_q;
    assign exc_miss_o  = 1'b0;

`ifdef FETCH_PERFCNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (inst_req && !inst_addr_ok) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perfcnt_fetch_stall = stall_cnt_q;
`else
    assign perfcnt_fetch_stall = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: direct output checks plus a scoreboard of slots
// expected to be consumed by decode.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        cancelled_o;
    logic        exc_o;
    logic        exc_miss_o;
    logic [4:0]  exccode_o;
    logic [31:0] perfcnt_fetch_stall;

    int unsigned checks;
    int unsigned failures;

`ifdef FETCH_PERFCNT_EN
    localparam logic [31:0] ExpStall = 32'd3;
`else
    localparam logic [31:0] ExpStall = 32'd0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        cancelled;
        logic        exc;
        logic [4:0]  code;
    } slot_t;

    slot_t sb[$];

    fetch_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .inst_req            (inst_req),
        .inst_addr           (inst_addr),
        .inst_addr_ok        (inst_addr_ok),
        .inst_data_ok        (inst_data_ok),
        .ready_i             (ready_i),
        .redirect_i          (redirect_i),
        .redirect_pc_i       (redirect_pc_i),
        .valid_o             (valid_o),
        .pc_o                (pc_o),
        .cancelled_o         (cancelled_o),
        .exc_o               (exc_o),
        .exc_miss_o          (exc_miss_o),
        .exccode_o           (exccode_o),
        .perfcnt_fetch_stall (perfcnt_fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst_v, input logic aok, input logic dok, input logic rdy,
                         input logic rdr, input logic [31:0] rpc);
        @(negedge clk);
        reset         = rst_v;
        inst_addr_ok  = aok;
        inst_data_ok  = dok;
        ready_i       = rdy;
        redirect_i    = rdr;
        redirect_pc_i = rpc;
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic c, input logic e);
        slot_t s;
        s.pc        = pc;
        s.cancelled = c;
        s.exc       = e;
        s.code      = e ? 5'h04 : 5'h00;
        sb.push_back(s);
    endtask

    // Slot consumption happens at the next rising edge with these inputs.
    always @(negedge clk) begin
        #2;
        if (!reset && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", sb.size(), 1);
            end else begin
                slot_t e;
                e = sb.pop_front();
                check_eq("sb_pc", pc_o, e.pc);
                check_eq("sb_cancelled", {31'd0, cancelled_o}, {31'd0, e.cancelled});
                check_eq("sb_exc", {31'd0, exc_o}, {31'd0, e.exc});
                if (e.exc) check_eq("sb_exccode", {27'd0, exccode_o}, {27'd0, e.code});
            end
        end
    end

    initial begin
        reset         = 1'b1;
        inst_addr_ok  = 1'b1;
        inst_data_ok  = 1'b1;
        ready_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        checks        = 0;
        failures      = 0;

        // Reset state
        drive(1, 1, 1, 1, 0, 32'd0);
        check_eq("rst_req", {31'd0, inst_req}, 0);
        check_eq("rst_addr", inst_addr, 32'hBFC00000);
        check_eq("rst_valid", {31'd0, valid_o}, 0);
        check_eq("rst_pc", pc_o, 0);
        check_eq("rst_cancel", {31'd0, cancelled_o}, 0);
        check_eq("rst_exc", {31'd0, exc_o}, 0);
        check_eq("rst_code", {27'd0, exccode_o}, 0);
        check_eq("rst_perf", perfcnt_fetch_stall, 0);
        check_eq("rst_miss", {31'd0, exc_miss_o}, 0);

        // Back-to-back streaming
        drive(0, 1, 1, 1, 0, 32'd0);
        check_eq("a0_req", {31'd0, inst_req}, 1);
        check_eq("a0_addr", inst_addr, 32'hBFC00000);
        drive(0, 1, 1, 1, 0, 32'd0);
        push(32'hBFC00000, 0, 0);
        check_eq("a1_valid", {31'd0, valid_o}, 1);
        check_eq("a1_pc", pc_o, 32'hBFC00000);
        check_eq("a1_addr", inst_addr, 32'hBFC00004);
        drive(0, 1, 1, 1, 0, 32'd0);
        push(32'hBFC00004, 0, 0);
        check_eq("a2_pc", pc_o, 32'hBFC00004);
        check_eq("a2_addr", inst_addr, 32'hBFC00008);
        drive(1, 1, 1, 1, 0, 32'd0);
        check_eq("a3_req", {31'd0, inst_req}, 0);
        check_eq("a3_valid", {31'd0, valid_o}, 0);
        check_eq("a3_addr", inst_addr, 32'hBFC00000);

        // Address not accepted for 3 cycles
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 32'd0);
            check_eq("b_req", {31'd0, inst_req}, 1);
            check_eq("b_addr", inst_addr, 32'hBFC00000);
            check_eq("b_valid", {31'd0, valid_o}, 0);
        end
        drive(0, 1, 0, 0, 0, 32'd0);
        check_eq("b_perf", perfcnt_fetch_stall, ExpStall);
        check_eq("b_valid_end", {31'd0, valid_o}, 0);
        check_eq("b_req_end", {31'd0, inst_req}, 1);

        // Delayed data: no second request while pending
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 32'd0);
            check_eq("c_req", {31'd0, inst_req}, 0);
            check_eq("c_pc", pc_o, 32'hBFC00000);
        end
        drive(0, 1, 1, 1, 0, 32'd0);
        push(32'hBFC00000, 0, 0);
        check_eq("c_req_data", {31'd0, inst_req}, 1);
        check_eq("c_addr", inst_addr, 32'hBFC00004);

        // Redirect while slot BFC00004 outstanding
        drive(0, 1, 0, 0, 1, 32'h80001000);
        check_eq("d_req_rdr", {31'd0, inst_req}, 0);
        check_eq("d_pc", pc_o, 32'hBFC00004);
        drive(0, 1, 1, 0, 0, 32'd0);
        check_eq("d_cancel", {31'd0, cancelled_o}, 1);
        check_eq("d_valid", {31'd0, valid_o}, 1);
        check_eq("d_req_busy", {31'd0, inst_req}, 0);
        check_eq("d_addr", inst_addr, 32'h80001000);
        drive(0, 1, 0, 1, 0, 32'd0);
        push(32'hBFC00004, 1, 0);
        check_eq("d_req", {31'd0, inst_req}, 1);
        check_eq("d_addr2", inst_addr, 32'h80001000);

        // Misaligned redirect target
        drive(0, 1, 1, 1, 1, 32'h80000002);
        push(32'h80001000, 0, 0);
        check_eq("e_cancel", {31'd0, cancelled_o}, 0);
        check_eq("e_pc0", pc_o, 32'h80001000);
        drive(0, 1, 0, 0, 0, 32'd0);
        check_eq("e_req0", {31'd0, inst_req}, 0);
        check_eq("e_addr", inst_addr, 32'h80000002);
        drive(0, 1, 0, 1, 0, 32'd0);
        push(32'h80000002, 0, 1);
        check_eq("e_valid", {31'd0, valid_o}, 1);
        check_eq("e_exc", {31'd0, exc_o}, 1);
        check_eq("e_code", {27'd0, exccode_o}, 32'h04);
        check_eq("e_pc", pc_o, 32'h80000002);
        check_eq("e_req1", {31'd0, inst_req}, 0);
        drive(0, 1, 0, 1, 0, 32'd0);
        check_eq("e_halt_req", {31'd0, inst_req}, 0);
        check_eq("e_halt_valid", {31'd0, valid_o}, 0);
        drive(0, 1, 0, 1, 1, 32'h80000000);
        check_eq("e_req_rdr", {31'd0, inst_req}, 0);
        drive(0, 1, 0, 1, 0, 32'd0);
        check_eq("e_req_resume", {31'd0, inst_req}, 1);
        check_eq("e_addr_resume", inst_addr, 32'h80000000);
        check_eq("e_perf", perfcnt_fetch_stall, ExpStall);

        // Reset with a request outstanding, data returns after release
        drive(1, 1, 0, 1, 0, 32'd0);
        check_eq("f_rst_req", {31'd0, inst_req}, 0);
        check_eq("f_rst_valid", {31'd0, valid_o}, 0);
        check_eq("f_rst_perf", perfcnt_fetch_stall, 0);
        drive(0, 1, 1, 1, 0, 32'd0);
        check_eq("f_req", {31'd0, inst_req}, 1);
        check_eq("f_addr", inst_addr, 32'hBFC00000);
        drive(0, 1, 0, 1, 0, 32'd0);
        push(32'hBFC00000, 0, 0);
        check_eq("f_req_pending", {31'd0, inst_req}, 0);
        drive(0, 1, 1, 1, 0, 32'd0);
        check_eq("f_req2", {31'd0, inst_req}, 1);
        check_eq("f_addr2", inst_addr, 32'hBFC00004);
        drive(0, 1, 1, 1, 0, 32'd0);
        push(32'hBFC00004, 0, 0);
        check_eq("f_addr3", inst_addr, 32'hBFC00008);

        // PC wrap at the top of the address space
        drive(0, 1, 1, 1, 1, 32'hFFFFFFFC);
        push(32'hBFC00008, 0, 0);
        check_eq("g_req_rdr", {31'd0, inst_req}, 0);
        drive(0, 1, 0, 1, 0, 32'd0);
        check_eq("g_req", {31'd0, inst_req}, 1);
        check_eq("g_addr", inst_addr, 32'hFFFFFFFC);
        drive(0, 1, 1, 1, 0, 32'd0);
        push(32'hFFFFFFFC, 0, 0);
        check_eq("g_pc", pc_o, 32'hFFFFFFFC);
        check_eq("g_addr_wrap", inst_addr, 32'h00000000);
        check_eq("g_req2", {31'd0, inst_req}, 1);

        drive(1, 1, 0, 1, 0, 32'd0);
        #4;
        check_eq("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
